// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with occupancy thresholds, registered read data and sticky error flags.
module fifo_umbrales #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH      = 3,
  parameter int unsigned ALMOST_FULL_TH  = 6,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] FIFO_data_in,
  output logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic                  FIFO_valid,
  output logic                  FIFO_empty,
  output logic                  FIFO_full,
  output logic                  FIFO_almost_full,
  output logic                  FIFO_almost_empty,
  output logic [ADDR_WIDTH:0]   FIFO_count,
  output logic                  FIFO_overflow,
  output logic                  FIFO_underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(ALMOST_FULL_TH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_drop;
  logic                  rd_refused;

  // Status flags decoded from the registered occupancy only
  always_comb begin
    FIFO_empty        = (FIFO_count == '0);
    FIFO_full         = (FIFO_count == CNT_FULL);
    FIFO_almost_full  = (FIFO_count >= CNT_AF);
    FIFO_almost_empty = (FIFO_count <= CNT_AE);
  end

  // Request qualification; a read frees a slot so a full FIFO can still take a write
  always_comb begin
    rd_acc     = Enable & read_enable & ~FIFO_empty;
    wr_acc     = Enable & write_enable & (~FIFO_full | rd_acc);
    wr_drop    = Enable & write_enable & FIFO_full & ~rd_acc;
    rd_refused = Enable & read_enable & FIFO_empty;
  end

  // Storage array; contents are not reset, stale entries are unreachable after reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= FIFO_data_in;
    end
  end

  // Pointers, occupancy, read data and sticky flags
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      FIFO_count     <= '0;
      FIFO_data_out  <= '0;
      FIFO_valid     <= 1'b0;
      FIFO_overflow  <= 1'b0;
      FIFO_underflow <= 1'b0;
    end else begin
      FIFO_valid <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr        <= rd_ptr + ADDR_WIDTH'(1);
        FIFO_data_out <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   FIFO_count <= FIFO_count + CNT_W'(1);
        2'b01:   FIFO_count <= FIFO_count - CNT_W'(1);
        default: FIFO_count <= FIFO_count;
      endcase
      if (wr_drop) begin
        FIFO_overflow <= 1'b1;
      end
      if (rd_refused) begin
        FIFO_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed self-checking bench for fifo_umbrales (DEPTH=8, AF=6, AE=2).
module tb_fifo_umbrales;

  logic       clk;
  logic       Reset;
  logic       Enable;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] FIFO_data_in;
  logic [7:0] FIFO_data_out;
  logic       FIFO_valid;
  logic       FIFO_empty;
  logic       FIFO_full;
  logic       FIFO_almost_full;
  logic       FIFO_almost_empty;
  logic [3:0] FIFO_count;
  logic       FIFO_overflow;
  logic       FIFO_underflow;

  int total = 0;
  int bad   = 0;

  fifo_umbrales #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)
  ) dut (
    .clk(clk), .Reset(Reset), .Enable(Enable),
    .write_enable(write_enable), .read_enable(read_enable),
    .FIFO_data_in(FIFO_data_in), .FIFO_data_out(FIFO_data_out),
    .FIFO_valid(FIFO_valid), .FIFO_empty(FIFO_empty), .FIFO_full(FIFO_full),
    .FIFO_almost_full(FIFO_almost_full), .FIFO_almost_empty(FIFO_almost_empty),
    .FIFO_count(FIFO_count), .FIFO_overflow(FIFO_overflow),
    .FIFO_underflow(FIFO_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of requests, then advance
  task automatic drive(input logic we, input logic re, input logic [7:0] d);
    write_enable = we;
    read_enable  = re;
    FIFO_data_in = d;
    step();
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  // Reset pulse away from the clock edge
  task automatic pulse_reset();
    Reset = 1'b1;
    #3;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Enable = 1'b1; write_enable = 1'b0; read_enable = 1'b0; FIFO_data_in = '0;
    step();
    step();
    total++; if (FIFO_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", FIFO_count); end
    total++; if ({FIFO_empty, FIFO_almost_empty, FIFO_full, FIFO_almost_full} !== 4'b1100) begin
      bad++; $display("FAIL reset_flags got=%b exp=1100", {FIFO_empty, FIFO_almost_empty, FIFO_full, FIFO_almost_full}); end
    total++; if ({FIFO_valid, FIFO_overflow, FIFO_underflow} !== 3'b000) begin
      bad++; $display("FAIL reset_valid_sticky got=%b exp=000", {FIFO_valid, FIFO_overflow, FIFO_underflow}); end
    total++; if (FIFO_data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", FIFO_data_out); end
    #3;
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] v [5];
    v[0] = 8'hFF; v[1] = 8'hAF; v[2] = 8'h17; v[3] = 8'hB8; v[4] = 8'h6A;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, v[i]);
      total++; if (FIFO_count !== 4'(i + 1)) begin bad++; $display("FAIL basic_wr_count i=%0d got=%0d exp=%0d", i, FIFO_count, i + 1); end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      total++; if (FIFO_valid !== 1'b1 || FIFO_data_out !== v[i]) begin
        bad++; $display("FAIL basic_rd i=%0d got=%b/%h exp=1/%h", i, FIFO_valid, FIFO_data_out, v[i]); end
      total++; if (FIFO_count !== 4'(4 - i)) begin bad++; $display("FAIL basic_rd_count i=%0d got=%0d exp=%0d", i, FIFO_count, 4 - i); end
    end
    step();
    total++; if (FIFO_valid !== 1'b0 || FIFO_empty !== 1'b1 || FIFO_data_out !== 8'h6A) begin
      bad++; $display("FAIL basic_end got=v%b e%b %h exp=v0 e1 6a", FIFO_valid, FIFO_empty, FIFO_data_out); end
  endtask

  task automatic test_thresholds();
    logic [3:0] c;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + i));
      c = 4'(i + 1);
      total++; if ({FIFO_almost_empty, FIFO_almost_full, FIFO_full} !== {c <= 4'd2, c >= 4'd6, c == 4'd8}) begin
        bad++; $display("FAIL thresh cnt=%0d got=%b exp=%b", c, {FIFO_almost_empty, FIFO_almost_full, FIFO_full},
                        {c <= 4'd2, c >= 4'd6, c == 4'd8}); end
    end
    total++; if (FIFO_overflow !== 1'b0) begin bad++; $display("FAIL thresh_no_ovf got=%b exp=0", FIFO_overflow); end
    drive(1'b1, 1'b0, 8'hEE);
    total++; if (FIFO_overflow !== 1'b1 || FIFO_count !== 4'd8) begin
      bad++; $display("FAIL overflow got=%b/%0d exp=1/8", FIFO_overflow, FIFO_count); end
    step();
    total++; if (FIFO_overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%b exp=1", FIFO_overflow); end
  endtask

  task automatic test_rw_full();
    pulse_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(8'h20 + i));
    drive(1'b1, 1'b1, 8'h5A);
    total++; if (FIFO_count !== 4'd8 || FIFO_overflow !== 1'b0) begin
      bad++; $display("FAIL rw_full got=%0d/%b exp=8/0", FIFO_count, FIFO_overflow); end
    total++; if (FIFO_valid !== 1'b1 || FIFO_data_out !== 8'h20) begin
      bad++; $display("FAIL rw_full_out got=%b/%h exp=1/20", FIFO_valid, FIFO_data_out); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      total++; if (FIFO_data_out !== ((i == 7) ? 8'h5A : 8'(8'h21 + i))) begin
        bad++; $display("FAIL rw_full_drain i=%0d got=%h exp=%h", i, FIFO_data_out, (i == 7) ? 8'h5A : 8'(8'h21 + i)); end
    end
    total++; if (FIFO_empty !== 1'b1) begin bad++; $display("FAIL rw_full_empty got=%b exp=1", FIFO_empty); end
  endtask

  task automatic test_rw_empty();
    drive(1'b1, 1'b1, 8'h3C);
    total++; if ({FIFO_underflow, FIFO_valid} !== 2'b10 || FIFO_count !== 4'd1) begin
      bad++; $display("FAIL rw_empty got=u%b v%b c%0d exp=u1 v0 c1", FIFO_underflow, FIFO_valid, FIFO_count); end
    drive(1'b0, 1'b1, 8'h00);
    total++; if (FIFO_valid !== 1'b1 || FIFO_data_out !== 8'h3C || FIFO_count !== 4'd0) begin
      bad++; $display("FAIL rw_empty_read got=%b/%h/%0d exp=1/3c/0", FIFO_valid, FIFO_data_out, FIFO_count); end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(8'h40 + 16 * r + i));
      for (int i = 0; i < 6; i++) begin
        e = 8'(8'h40 + 16 * r + i);
        drive(1'b0, 1'b1, 8'h00);
        total++; if (FIFO_valid !== 1'b1 || FIFO_data_out !== e) begin
          bad++; $display("FAIL wrap r=%0d i=%0d got=%b/%h exp=1/%h", r, i, FIFO_valid, FIFO_data_out, e); end
      end
    end
  endtask

  task automatic test_enable();
    pulse_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h90 + i));
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 8'h94);
    Enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 8'hC0);
      total++; if (FIFO_count !== 4'd4 || FIFO_valid !== 1'b0 || FIFO_data_out !== 8'h90) begin
        bad++; $display("FAIL disabled i=%0d got=%0d/%b/%h exp=4/0/90", i, FIFO_count, FIFO_valid, FIFO_data_out); end
      total++; if ({FIFO_overflow, FIFO_underflow} !== 2'b00) begin
        bad++; $display("FAIL disabled_sticky i=%0d got=%b exp=00", i, {FIFO_overflow, FIFO_underflow}); end
    end
    Enable = 1'b1;
    drive(1'b0, 1'b1, 8'h00);
    total++; if (FIFO_data_out !== 8'h91 || FIFO_count !== 4'd3) begin
      bad++; $display("FAIL reenable got=%h/%0d exp=91/3", FIFO_data_out, FIFO_count); end
    drive(1'b1, 1'b0, 8'h95);
    Reset = 1'b1;
    #2;
    total++; if (FIFO_count !== 4'd0 || FIFO_empty !== 1'b1 || {FIFO_overflow, FIFO_underflow, FIFO_valid} !== 3'b000) begin
      bad++; $display("FAIL async_reset got=%0d e%b s%b exp=0 e1 s000", FIFO_count, FIFO_empty,
                      {FIFO_overflow, FIFO_underflow, FIFO_valid}); end
    Reset = 1'b0;
    drive(1'b0, 1'b1, 8'h00);
    total++; if (FIFO_underflow !== 1'b1 || FIFO_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_empty got=%b/%b exp=1/0", FIFO_underflow, FIFO_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_thresholds();
    test_rw_full();
    test_rw_empty();
    test_wrap();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
